// File: rtl/pmem_loader.sv
// pmem_loader: packs a host byte stream into 12-bit instruction words and writes
// them to program memory at sequential addresses while the control unit holds LOAD.
//
// Word format (two bytes, low byte first):
//   byte1 = instr[7:0]
//   byte2 = {tag[3:0], instr[11:8]}; tag 0 = normal word, tag F = end of program,
//           any other tag = format error (word dropped).
//
// Ports:
//   clk_i          system clock, rising edge
//   rst_i          asynchronous active-high reset
//   pmem_le_i      load enable from the control unit's LOAD state
//   in_data_i      host byte
//   in_valid_i     in_data_i is valid
//   in_ready_o     byte accepted on an edge where in_valid_i && in_ready_o
//   pmem_addr_o    program memory write address
//   pmem_wdata_o   instruction word to write
//   pmem_we_o      one-cycle write strobe
//   word_count_o   words written in the current load (saturates at DEPTH)
//   load_done_o    sticky: end marker seen or memory full
//   fmt_err_o      sticky: at least one word carried an illegal tag
module pmem_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DEPTH  = 256
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pmem_le_i,
   input  logic [7:0]        in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic [ADDR_W-1:0] pmem_addr_o,
   output logic [11:0]       pmem_wdata_o,
   output logic              pmem_we_o,
   output logic [ADDR_W:0]   word_count_o,
   output logic              load_done_o,
   output logic              fmt_err_o
);

   typedef enum logic [2:0] {StIdle, StLo, StHi, StWrite, StDone} state_e;

   localparam logic [ADDR_W:0] DepthCnt = (ADDR_W+1)'(DEPTH);
   localparam logic [3:0]      TagWord  = 4'h0;
   localparam logic [3:0]      TagEnd   = 4'hF;

   state_e              state_q;
   logic                le_q;
   logic [7:0]          byte1_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [11:0]         wdata_q;
   logic                we_q;
   logic [ADDR_W:0]     count_q;
   logic                done_q;
   logic                err_q;

   logic                xfer;
   logic [ADDR_W:0]     count_inc;

   // Ready drops combinationally with the load enable so no byte slips in on abort.
   assign in_ready_o = pmem_le_i && ((state_q == StLo) || (state_q == StHi));
   assign xfer       = in_valid_i && in_ready_o;
   assign count_inc  = count_q + 1'b1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         le_q    <= 1'b0;
         byte1_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         count_q <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         le_q <= pmem_le_i;
         we_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (pmem_le_i && !le_q) begin
                  // Rising edge of the load enable: start a fresh load.
                  addr_q  <= '0;
                  count_q <= '0;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= StLo;
               end else if (pmem_le_i && !done_q) begin
                  state_q <= StLo;
               end
            end
            StLo: begin
               if (!pmem_le_i) begin
                  byte1_q <= '0;
                  state_q <= StIdle;
               end else if (xfer) begin
                  byte1_q <= in_data_i;
                  state_q <= StHi;
               end
            end
            StHi: begin
               if (!pmem_le_i) begin
                  byte1_q <= '0;
                  state_q <= StIdle;
               end else if (xfer) begin
                  byte1_q <= '0;
                  if (in_data_i[7:4] == TagWord) begin
                     wdata_q <= {in_data_i[3:0], byte1_q};
                     we_q    <= 1'b1;
                     state_q <= StWrite;
                  end else if (in_data_i[7:4] == TagEnd) begin
                     done_q  <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     err_q   <= 1'b1;
                     state_q <= StLo;
                  end
               end
            end
            StWrite: begin
               // Strobe always completes; address wraps naturally at DEPTH = 2**ADDR_W.
               addr_q  <= addr_q + 1'b1;
               count_q <= count_inc;
               if (count_inc == DepthCnt) begin
                  done_q  <= 1'b1;
                  state_q <= pmem_le_i ? StDone : StIdle;
               end else begin
                  state_q <= pmem_le_i ? StLo : StIdle;
               end
            end
            StDone: begin
               if (!pmem_le_i) begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign pmem_addr_o  = addr_q;
   assign pmem_wdata_o = wdata_q;
   assign pmem_we_o    = we_q;
   assign word_count_o = count_q;
   assign load_done_o  = done_q;
   assign fmt_err_o    = err_q;

endmodule
